// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing the MiST SD block request channel between two
// requesters. Sequences the rd/wr -> ack handshake and steers the sector
// buffer strobe/data to the granted requester.
module sd_sector_arbiter #(
  parameter int unsigned TO_BITS = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  req_busy,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [1:0]  buff_wr,
  input  logic [7:0]  buff_din0,
  input  logic [7:0]  buff_din1,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StXfer,
    StDone,
    StErr
  } state_e;

  localparam logic [TO_BITS-1:0] CntMax = '1;
  localparam logic [TO_BITS-1:0] CntOne = TO_BITS'(1);

  state_e             r_state, w_state_nxt;
  logic               r_grant, w_grant_nxt;
  logic               r_last, w_last_nxt;
  logic [TO_BITS-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]        r_sd_lba, w_sd_lba_nxt;
  logic               r_sd_rd, w_sd_rd_nxt;
  logic               r_sd_wr, w_sd_wr_nxt;
  logic [1:0]         r_busy, w_busy_nxt;
  logic [1:0]         r_done, w_done_nxt;
  logic [1:0]         r_err, w_err_nxt;

  logic r_ack_meta, r_ack_s, r_ack_d;
  logic w_ack_rise, w_ack_fall;

  logic [1:0] w_pend;
  logic       w_pick;
  logic       w_pick_wr;
  logic       w_route;

  // Two-flop synchronizer plus delay flop for edge detection of sd_ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_ack_d    <= 1'b0;
    end else begin
      r_ack_meta <= sd_ack;
      r_ack_s    <= r_ack_meta;
      r_ack_d    <= r_ack_s;
    end
  end

  assign w_ack_rise = r_ack_s & ~r_ack_d;
  assign w_ack_fall = ~r_ack_s & r_ack_d;

  // Grant selection: a lone pending requester wins, a tie goes to the one not served last.
  assign w_pend    = req_rd | req_wr;
  assign w_pick    = (w_pend == 2'b11) ? ~r_last : ~w_pend[0];
  // Read takes precedence when a requester raises both rd and wr.
  assign w_pick_wr = w_pick ? (~req_rd[1] & req_wr[1]) : (~req_rd[0] & req_wr[0]);

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_sd_lba_nxt = r_sd_lba;
    w_sd_rd_nxt  = r_sd_rd;
    w_sd_wr_nxt  = r_sd_wr;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 2'b00;
    w_err_nxt    = 2'b00;

    unique case (r_state)
      StIdle: begin
        if (|w_pend) begin
          w_grant_nxt  = w_pick;
          w_sd_lba_nxt = w_pick ? req_lba1 : req_lba0;
          w_busy_nxt   = w_pick ? 2'b10 : 2'b01;
          w_cnt_nxt    = '0;
          w_sd_rd_nxt  = ~w_pick_wr;
          w_sd_wr_nxt  = w_pick_wr;
          w_state_nxt  = StReq;
        end
      end
      StReq: begin
        if (w_ack_rise) begin
          w_sd_rd_nxt = 1'b0;
          w_sd_wr_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = StXfer;
        end else if (r_cnt == CntMax) begin
          w_sd_rd_nxt = 1'b0;
          w_sd_wr_nxt = 1'b0;
          w_state_nxt = StErr;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StXfer: begin
        if (w_ack_fall) begin
          w_state_nxt = StDone;
        end else if (r_cnt == CntMax) begin
          w_state_nxt = StErr;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StDone: begin
        w_done_nxt  = r_grant ? 2'b10 : 2'b01;
        w_busy_nxt  = 2'b00;
        w_last_nxt  = r_grant;
        w_state_nxt = StIdle;
      end
      StErr: begin
        w_err_nxt   = r_grant ? 2'b10 : 2'b01;
        w_busy_nxt  = 2'b00;
        w_last_nxt  = r_grant;
        w_state_nxt = StIdle;
      end
      default: begin
        w_sd_rd_nxt = 1'b0;
        w_sd_wr_nxt = 1'b0;
        w_busy_nxt  = 2'b00;
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and registered outputs; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_sd_lba <= 32'h0;
      r_sd_rd  <= 1'b0;
      r_sd_wr  <= 1'b0;
      r_busy   <= 2'b00;
      r_done   <= 2'b00;
      r_err    <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sd_lba <= w_sd_lba_nxt;
      r_sd_rd  <= w_sd_rd_nxt;
      r_sd_wr  <= w_sd_wr_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign w_route = (r_state == StReq) || (r_state == StXfer);

  // Buffer steering to the granted requester while a transfer is in flight.
  always_comb begin
    buff_wr     = 2'b00;
    sd_buff_din = 8'h00;
    if (w_route) begin
      if (r_grant) begin
        buff_wr     = {sd_buff_wr, 1'b0};
        sd_buff_din = buff_din1;
      end else begin
        buff_wr     = {1'b0, sd_buff_wr};
        sd_buff_din = buff_din0;
      end
    end
  end

  assign req_busy = r_busy;
  assign req_done = r_done;
  assign req_err  = r_err;
  assign sd_lba   = r_sd_lba;
  assign sd_rd    = r_sd_rd;
  assign sd_wr    = r_sd_wr;

endmodule

// File: doc/sd_sector_arbiter.md
# sd_sector_arbiter

Shares the single SD block-level request channel of the MiST I/O controller (sd_lba / sd_rd / sd_wr / sd_ack plus the 512-byte sector buffer port) between two requesters, e.g. a floppy and a hard-disk emulator. It arbitrates round-robin, sequences the rd/wr → ack handshake, and routes buffer traffic to the granted requester. It sits between the core's disk controllers and the I/O controller, entirely in clk_sys.

## Interface
Parameters:
- TO_BITS, 24: width of the handshake timeout counter; timeout = 2^TO_BITS − 1 clk_sys cycles per phase.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_rd  in  2  per-requester read request (level, held until done/err).
- req_wr  in  2  per-requester write request (level, held until done/err).
- req_lba0, req_lba1  in  32  sector LBA of requester 0 / 1.
- req_busy  out  2  one-hot: requester currently granted.
- req_done  out  2  one-cycle pulse: transfer completed.
- req_err  out  2  one-cycle pulse: transfer timed out.
- buff_wr  out  2  per-requester sector-buffer write strobe (read data path).
- buff_din0, buff_din1  in  8  per-requester buffer data for writes.
- sd_lba  out  32  LBA presented to the I/O controller.
- sd_rd, sd_wr  out  1  block request to the I/O controller.
- sd_ack  in  1  transfer acknowledge; asynchronous to clk_sys.
- sd_buff_wr  in  1  buffer write strobe from I/O controller.
- sd_buff_din  out  8  buffer data returned to I/O controller.

sd_buff_addr / sd_buff_dout fan out to requesters directly; not routed by this block.

## Operation
- Reset (async, reset_n=0): state IDLE; sd_rd, sd_wr, req_busy, req_done, req_err, buff_wr = 0; sd_lba = 0; last = 1 (so requester 0 wins first tie); timeout counter 0.
- sd_ack passes a 2-flop synchronizer (ack_s) and a delay flop (ack_d); rise = ack_s & ~ack_d, fall = ~ack_s & ack_d.
- Request of requester i: pend[i] = req_rd[i] | req_wr[i]. If both rd and wr asserted, read wins.
- States:
  - IDLE: if exactly one pend → grant it; if both → grant ~last. On grant: latch sd_lba, direction, req_busy[g]=1, clear counter, assert sd_rd or sd_wr, go REQ.
  - REQ: hold sd_rd/sd_wr. On ack rise → drop sd_rd/sd_wr, clear counter, go XFER. Counter reaching max → drop sd_rd/sd_wr, go ERR.
  - XFER: route buffer; on ack fall → go DONE. Counter max → ERR.
  - DONE: req_done[g]=1 one cycle, req_busy=0, last=g, go IDLE.
  - ERR: req_err[g]=1 one cycle, req_busy=0, last=g, go IDLE.
- Buffer routing (combinational from registered grant): in REQ and XFER, buff_wr[g] = sd_buff_wr, other bit 0; sd_buff_din = buffer of g. In IDLE/DONE/ERR buff_wr = 0, sd_buff_din = 0.
- Requester dropping its request mid-transfer is ignored; transfer runs to DONE/ERR.
- sd_lba stable from grant until next grant.

## Timing
- Request asserted before edge N in IDLE → sd_rd/sd_wr and req_busy high after edge N.
- sd_ack pin rise → sd_rd/sd_wr low 3 edges later (2 sync + state update).
- sd_ack pin fall → req_done pulse registered 4 edges later (sync, fall-detect, DONE).
- After DONE/ERR, earliest next grant is the following edge (one idle cycle minimum between transfers).
- Counter increments every cycle in REQ/XFER; saturation at 2^TO_BITS−1 triggers ERR next edge.

## Test plan
- Single read: req_rd[0]=1, req_lba0=0x12345678; ack high 10 cycles later for 600 cycles → sd_lba=0x12345678, sd_rd high until 3 cycles after ack rise, req_done[0] pulse once, sd_wr never high.
- Contention: req_rd[0] and req_wr[1] same cycle after reset → requester 0 first; requester 1 granted the cycle after req_done[0]; then both again → requester 0 (round-robin).
- Buffer routing: requester 1 read, 512 sd_buff_wr strobes during XFER → buff_wr[1] mirrors every strobe, buff_wr[0] stays 0; write from requester 1 with buff_din1=0xA5, buff_din0=0x5A → sd_buff_din=0xA5.
- Timeout: TO_BITS=4, no ack → sd_rd drops and req_err[0] pulses after 15 cycles in REQ; req_done never pulses.
- Reset mid-XFER: reset_n low during XFER → all outputs 0 immediately; after release, held request is re-granted from IDLE.
- rd+wr both set on requester 0 → only sd_rd asserted.
